// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions: opcodes, control-field encodings and the
// Execute control word layout.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

    localparam logic PCSEL2_NPC  = 1'b1;
    localparam logic PCSEL2_VSR1 = 1'b0;

    localparam logic OP2_VSR2 = 1'b1;
    localparam logic OP2_IMM5 = 1'b0;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;

    localparam logic MEM_DIRECT   = 1'b0;
    localparam logic MEM_INDIRECT = 1'b1;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational opcode decoder: instruction word to Execute/Writeback/MemAccess
// control words. Unlisted fields and unused opcodes decode to zero.
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  logic [15:0] instr,
    output logic [5:0]  e_control,
    output logic [1:0]  w_control,
    output logic        mem_control
);

    e_ctrl_t e;
    op_e     op;

    assign op = op_e'(instr[15:12]);

    always_comb begin
        e           = '0;
        w_control   = WSEL_ALU;
        mem_control = MEM_DIRECT;
        case (op)
            OP_ADD: begin
                e.alu_control = ALU_ADD;
                e.op2select   = ~instr[5];
            end
            OP_AND: begin
                e.alu_control = ALU_AND;
                e.op2select   = ~instr[5];
            end
            OP_NOT: begin
                e.alu_control = ALU_NOT;
                e.op2select   = OP2_VSR2;
            end
            OP_BR: begin
                e.pcselect1 = PCSEL1_OFF9;
                e.pcselect2 = PCSEL2_NPC;
            end
            OP_JMP: begin
                e.pcselect1 = PCSEL1_ZERO;
                e.pcselect2 = PCSEL2_VSR1;
            end
            OP_LD, OP_LDI: begin
                e.pcselect1 = PCSEL1_OFF9;
                e.pcselect2 = PCSEL2_NPC;
                w_control   = WSEL_MEM;
                mem_control = (op == OP_LDI) ? MEM_INDIRECT : MEM_DIRECT;
            end
            OP_LDR: begin
                e.pcselect1 = PCSEL1_OFF6;
                e.pcselect2 = PCSEL2_VSR1;
                w_control   = WSEL_MEM;
            end
            OP_LEA: begin
                e.pcselect1 = PCSEL1_OFF9;
                e.pcselect2 = PCSEL2_NPC;
                w_control   = WSEL_PC;
            end
            OP_ST, OP_STI: begin
                e.pcselect1 = PCSEL1_OFF9;
                e.pcselect2 = PCSEL2_NPC;
                mem_control = (op == OP_STI) ? MEM_INDIRECT : MEM_DIRECT;
            end
            OP_STR: begin
                e.pcselect1 = PCSEL1_OFF6;
                e.pcselect2 = PCSEL2_VSR1;
            end
            default: ;
        endcase
    end

    assign e_control = e;

endmodule

// File: rtl/lc3_decode.sv
// LC3 Decode stage: registers the fetched instruction and NPC together with
// the decoded control words; all outputs update only on an enabled edge.
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_decode,
    input  logic [DATA_WIDTH-1:0] Instr_dout,
    input  logic [DATA_WIDTH-1:0] npc_in,
    output logic [DATA_WIDTH-1:0] IR,
    output logic [DATA_WIDTH-1:0] npc_out,
    output logic [5:0]            E_Control,
    output logic [1:0]            W_Control,
    output logic                  Mem_Control
);

    generate
        if (DATA_WIDTH != 16) begin : g_bad_width
            $error("lc3_decode: DATA_WIDTH must be 16");
        end
    endgenerate

    logic [5:0]            e_ctrl_p0;
    logic [1:0]            w_ctrl_p0;
    logic                  mem_ctrl_p0;
    logic [DATA_WIDTH-1:0] ir_p1;
    logic [DATA_WIDTH-1:0] npc_p1;
    logic [5:0]            e_ctrl_p1;
    logic [1:0]            w_ctrl_p1;
    logic                  mem_ctrl_p1;

    lc3_decode_ctrl u_ctrl (
        .instr       (Instr_dout),
        .e_control   (e_ctrl_p0),
        .w_control   (w_ctrl_p0),
        .mem_control (mem_ctrl_p0)
    );

    // p0 -> p1: capture instruction, NPC and decode together so they never diverge
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_p1       <= '0;
            npc_p1      <= '0;
            e_ctrl_p1   <= '0;
            w_ctrl_p1   <= '0;
            mem_ctrl_p1 <= 1'b0;
        end else if (enable_decode) begin
            ir_p1       <= Instr_dout;
            npc_p1      <= npc_in;
            e_ctrl_p1   <= e_ctrl_p0;
            w_ctrl_p1   <= w_ctrl_p0;
            mem_ctrl_p1 <= mem_ctrl_p0;
        end
    end

    assign IR          = ir_p1;
    assign npc_out     = npc_p1;
    assign E_Control   = e_ctrl_p1;
    assign W_Control   = w_ctrl_p1;
    assign Mem_Control = mem_ctrl_p1;

endmodule
